coin_sensor_front: RTL and testbench
====================================

Name: coin_sensor_front

Overview:
- Upstream stage of the vending controller. Turns the raw, asynchronous, bouncy nickel/dime slot sensors into clean one-cycle coin codes.
- Its `coin` output drives the controller's 5-bit coin input directly: 5 or 10 for one cycle, otherwise 0.
- Adds per-channel synchronisation, debounce, conflict rejection, an accept gate and stuck-sensor (jam) detection.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to qualify a press or a release (range 1..255).
- STUCK_CYCLES, 1000, cycles a channel may remain in HELD before jam is declared (must be greater than DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- sens5_raw  input  1  raw 5-unit slot sensor; asynchronous, may bounce.
- sens10_raw  input  1  raw 10-unit slot sensor; asynchronous, may bounce.
- accept_en  input  1  high = coins may be credited; low = coins are returned.
- coin  output  5  registered coin code: 0, 5 or 10.
- reject  output  1  registered one-cycle pulse: the coin is routed to the return chute.
- jam  output  1  sticky flag: a sensor was held too long.

Behaviour:
- Reset: when rst is sampled high, all sync flops, debounce states and counters clear. coin=0, reject=0, jam=0 from the next cycle.
- Sync: each raw input passes through a 2-flop synchroniser; call the output s.
- Debounce FSM, one per channel:
  - IDLE: if s=1, go to RISE_WAIT with cnt=1. If DEBOUNCE_CYCLES=1, go straight to HELD and raise the event.
  - RISE_WAIT: if s=1, cnt++. When cnt reaches DEBOUNCE_CYCLES, go to HELD and raise the press event for exactly one cycle. If s=0, return to IDLE and clear cnt.
  - HELD: count held cycles. If s=0, go to FALL_WAIT with cnt=1. If the held count reaches STUCK_CYCLES, set jam.
  - FALL_WAIT: if s=0, cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE. If s=1, return to HELD; the held count continues and no new event is raised.
- Latency: raw first sampled high at edge 0 → the event forms at edge 1+DEBOUNCE_CYCLES → coin/reject are registered at edge 2+DEBOUNCE_CYCLES. Total latency is 2+DEBOUNCE_CYCLES cycles, which is 6 at the default.
- Output register, loaded every cycle:
  - Single 5 event, accept_en=1, jam=0: coin=5, reject=0.
  - Single 10 event, accept_en=1, jam=0: coin=10, reject=0.
  - Both channels raise events in the same cycle: coin=0, reject=1. No credit is given.
  - Any event while accept_en=0 or jam=1: coin=0, reject=1. accept_en is sampled in the event cycle.
  - No event: coin=0, reject=0.
- coin and reject are never non-zero in the same cycle. Each physical press produces at most one pulse.
- An event on one channel while the other channel is in HELD is a normal single event.
- Jam: sticky until rst; it does not stop the FSMs. A channel that jammed still needs release + debounce before it can raise another event.
- Reset mid-debounce: the partial count is discarded and no event is raised. A sensor still high after reset must qualify again from IDLE.
- Counter widths: cnt is 8 bits; the held counter is $clog2(STUCK_CYCLES+1) bits and saturates.

Decomposition:
- Package `vending_pkg` holds:
  - the coin constants COIN_NONE=5'd0, COIN_5=5'd5, COIN_10=5'd10, shared with the vending controller;
  - the debounce state enum (IDLE, RISE_WAIT, HELD, FALL_WAIT).
- Sub-module `coin_debounce`, instantiated twice, contains:
  - the 2-flop sync and the debounce FSM;
  - outputs: a one-cycle press event and a stuck flag.
- The top level holds the arbitration, the output register and the sticky jam.

Test Plan:
- Clean insert: rst for 2 cycles, accept_en=1, sens5_raw high for 20 cycles → coin=5 for exactly one cycle at edge 6 after the first high sample; no further pulse on release.
- Bounce: sens10_raw toggling 1,0,1,1,0 then steady high → the chatter raises no event; coin=10 once, 6 cycles after the steady high begins. Release with bounces → no extra event.
- Simultaneous: both raw inputs rise on the same edge, each held 10 cycles → coin stays 0 and reject=1 for one cycle.
- Gated: accept_en=0, sens5 press → reject pulse and coin=0. Raise accept_en, press sens10 → coin=10.
- Jam: STUCK_CYCLES=20, hold sens5_raw high for 40 cycles → coin=5 once, then jam=1 and it stays high. A later sens10 press gives reject=1, coin=0. Asserting rst clears jam.
- Reset mid-operation: assert rst during RISE_WAIT with the sensor still high → no coin. After rst deasserts, coin=5 arrives a full 2+DEBOUNCE_CYCLES cycles later.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared coin codes and debounce state type for the vending datapath.
package vending_pkg;

  localparam logic [4:0] COIN_NONE = 5'd0;
  localparam logic [4:0] COIN_5    = 5'd5;
  localparam logic [4:0] COIN_10   = 5'd10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    HELD      = 2'd2,
    FALL_WAIT = 2'd3
  } deb_state_e;

  typedef struct packed {
    logic [4:0] coin;
    logic       reject;
  } coin_out_t;

  // Conflicting, gated or jammed events go to the return chute with no credit.
  function automatic coin_out_t arbitrate(input logic ev5, input logic ev10,
                                          input logic accept, input logic jammed);
    coin_out_t o;
    o.coin   = COIN_NONE;
    o.reject = 1'b0;
    if (ev5 && ev10) begin
      o.reject = 1'b1;
    end else if (ev5 || ev10) begin
      if (!accept || jammed) begin
        o.reject = 1'b1;
      end else begin
        o.coin = ev5 ? COIN_5 : COIN_10;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One slot-sensor channel: 2-flop sync, debounce FSM, press event and stuck flag.
// state     | meaning
// IDLE      | sensor released and qualified
// RISE_WAIT | counting stable high samples
// HELD      | press qualified, held counter running
// FALL_WAIT | counting stable low samples
module coin_debounce
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sens_raw_i,
  output logic press_o,
  output logic stuck_o
);

  localparam int unsigned HW = $clog2(STUCK_CYCLES + 1);
  localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] STUCK = HW'(STUCK_CYCLES);

  logic          sync1_q;
  logic          s_q;
  deb_state_e    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [HW-1:0] held_q, held_d;
  logic          press_q, press_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sens_raw_i;
      s_q     <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        held_d = '0;
        if (s_q) begin
          if (DEB == 8'd1) begin
            state_d = HELD;
          end else begin
            state_d = RISE_WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      RISE_WAIT: begin
        held_d = '0;
        if (s_q) begin
          if (cnt_q + 8'd1 == DEB) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HELD: begin
        // Saturates so the stuck flag stays up for as long as the press lasts.
        held_d = (held_q == STUCK) ? held_q : held_q + HW'(1);
        if (!s_q) begin
          if (DEB == 8'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = FALL_WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      FALL_WAIT: begin
        if (!s_q) begin
          if (cnt_q + 8'd1 == DEB) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = '0;
      end
    endcase
  end

  // A press is raised only on entry to HELD from the rising side, never on a FALL_WAIT bounce.
  always_comb begin
    press_d = (state_d == HELD) && ((state_q == IDLE) || (state_q == RISE_WAIT));
  end

  assign press_o = press_q;
  assign stuck_o = (held_q == STUCK);

endmodule

// File: rtl/coin_sensor_front.sv
// Slot-sensor front end: two debounced channels, arbitration, registered coin/reject and sticky jam.
module coin_sensor_front
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sens5_raw,
  input  logic       sens10_raw,
  input  logic       accept_en,
  output logic [4:0] coin,
  output logic       reject,
  output logic       jam
);

  logic      ev5, ev10;
  logic      stuck5, stuck10;
  coin_out_t out_q, out_d;
  logic      jam_q, jam_d;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_deb5 (
    .clk        (clk),
    .rst        (rst),
    .sens_raw_i (sens5_raw),
    .press_o    (ev5),
    .stuck_o    (stuck5)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_deb10 (
    .clk        (clk),
    .rst        (rst),
    .sens_raw_i (sens10_raw),
    .press_o    (ev10),
    .stuck_o    (stuck10)
  );

  always_comb begin
    out_d = arbitrate(ev5, ev10, accept_en, jam_q);
    jam_d = jam_q | stuck5 | stuck10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '{coin: COIN_NONE, reject: 1'b0};
      jam_q <= 1'b0;
    end else begin
      out_q <= out_d;
      jam_q <= jam_d;
    end
  end

  assign coin   = out_q.coin;
  assign reject = out_q.reject;
  assign jam    = jam_q;

endmodule

// File: tb/tb_coin_sensor_front.sv
// Directed and randomized bench for coin_sensor_front against a run-length sensor model.
module tb_coin_sensor_front;
  import vending_pkg::*;

  localparam int DEB = 4;
  localparam int STK = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sens5_raw = 1'b0;
  logic       sens10_raw = 1'b0;
  logic       accept_en = 1'b0;
  logic [4:0] coin;
  logic       reject;
  logic       jam;

  coin_sensor_front #(
    .DEBOUNCE_CYCLES (DEB),
    .STUCK_CYCLES    (STK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sens5_raw  (sens5_raw),
    .sens10_raw (sens10_raw),
    .accept_en  (accept_en),
    .coin       (coin),
    .reject     (reject),
    .jam        (jam)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Model: per channel, a qualified level plus the length of the current run of
  // samples disagreeing with it; a run of DEB flips the level.
  bit m_pressed [2];
  int m_run     [2];
  int m_held    [2];
  bit m_jam;
  bit ev5_at  [int];
  bit ev10_at [int];
  bit jam_at  [int];
  logic [4:0] exp_coin;
  logic       exp_rej;
  logic       exp_jam;

  int n5, n10, nrej, last_coin_t;

  function automatic void chan(input int c, input bit s, input int now);
    bit was_held;
    was_held = m_pressed[c] && (m_run[c] == 0);
    if (was_held) begin
      if (m_held[c] < STK) m_held[c]++;
      if (m_held[c] == STK) jam_at[now + 3] = 1'b1;
    end
    if (s != m_pressed[c]) m_run[c]++;
    else m_run[c] = 0;
    if (m_run[c] == DEB) begin
      m_pressed[c] = !m_pressed[c];
      m_run[c] = 0;
      if (m_pressed[c]) begin
        m_held[c] = 0;
        if (c == 0) ev5_at[now + 3] = 1'b1;
        else ev10_at[now + 3] = 1'b1;
      end
    end
  endfunction

  function automatic void model(input bit r, input bit b5, input bit b10,
                                input bit acc, input int now);
    bit e5, e10;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_pressed[c] = 1'b0;
        m_run[c] = 0;
        m_held[c] = 0;
      end
      m_jam = 1'b0;
      ev5_at.delete();
      ev10_at.delete();
      jam_at.delete();
      exp_coin = COIN_NONE;
      exp_rej = 1'b0;
      exp_jam = 1'b0;
      return;
    end
    e5  = ev5_at.exists(now);
    e10 = ev10_at.exists(now);
    exp_coin = COIN_NONE;
    exp_rej = 1'b0;
    if (e5 && e10) exp_rej = 1'b1;
    else if (e5 || e10) begin
      if (!acc || m_jam) exp_rej = 1'b1;
      else exp_coin = e5 ? 5'd5 : 5'd10;
    end
    if (jam_at.exists(now)) m_jam = 1'b1;
    chan(0, b5, now);
    chan(1, b10, now);
    exp_jam = m_jam;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  task automatic tick(input bit b5, input bit b10, input bit acc, input bit r);
    sens5_raw  = b5;
    sens10_raw = b10;
    accept_en  = acc;
    rst        = r;
    @(posedge clk);
    model(r, b5, b10, acc, t);
    #1;
    chk("coin", 32'(coin), 32'(exp_coin));
    chk("reject", 32'(reject), 32'(exp_rej));
    chk("jam", 32'(jam), 32'(exp_jam));
    if (coin == 5'd5) begin n5++; last_coin_t = t; end
    if (coin == 5'd10) begin n10++; last_coin_t = t; end
    if (reject) nrej++;
    t++;
  endtask

  task automatic hold(input bit b5, input bit b10, input bit acc, input int n);
    for (int i = 0; i < n; i++) tick(b5, b10, acc, 1'b0);
  endtask

  task automatic clear_counts();
    n5 = 0; n10 = 0; nrej = 0; last_coin_t = -1;
  endtask

  initial begin
    int st;
    bit r5, r10, racc;

    // Reset
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("reset_coin", 32'(coin), 32'd0);
    chk("reset_jam", 32'(jam), 32'd0);

    // Clean insert
    clear_counts();
    st = t;
    hold(1, 0, 1, 20);
    hold(0, 0, 1, 12);
    chk("clean_count", n5, 1);
    chk("clean_latency", last_coin_t, st + 6);

    // Bounce on press and release
    clear_counts();
    tick(0, 1, 1, 0); tick(0, 0, 1, 0); tick(0, 1, 1, 0); tick(0, 1, 1, 0); tick(0, 0, 1, 0);
    st = t;
    hold(0, 1, 1, 15);
    tick(0, 0, 1, 0); tick(0, 1, 1, 0); tick(0, 0, 1, 0); tick(0, 0, 1, 0); tick(0, 1, 1, 0);
    hold(0, 0, 1, 12);
    chk("bounce_count", n10, 1);
    chk("bounce_latency", last_coin_t, st + 6);
    chk("bounce_rej", nrej, 0);

    // Simultaneous press
    clear_counts();
    hold(1, 1, 1, 10);
    hold(0, 0, 1, 12);
    chk("simul_rej", nrej, 1);
    chk("simul_coin", n5 + n10, 0);

    // Gated by accept_en, then accepted
    clear_counts();
    hold(1, 0, 0, 10);
    hold(0, 0, 0, 12);
    chk("gated_rej", nrej, 1);
    chk("gated_coin", n5, 0);
    hold(0, 1, 1, 10);
    hold(0, 0, 1, 12);
    chk("accept_coin", n10, 1);

    // Jam
    clear_counts();
    hold(1, 0, 1, 40);
    hold(0, 0, 1, 12);
    chk("jam_coin", n5, 1);
    chk("jam_set", 32'(jam), 32'd1);
    hold(0, 1, 1, 10);
    hold(0, 0, 1, 12);
    chk("jam_rej", nrej, 1);
    chk("jam_nocredit", n10, 0);
    chk("jam_sticky", 32'(jam), 32'd1);
    tick(0, 0, 1, 1);
    chk("jam_cleared", 32'(jam), 32'd0);

    // Reset mid-debounce with sensor still high
    clear_counts();
    hold(1, 0, 1, 3);
    tick(1, 0, 1, 1);
    tick(1, 0, 1, 1);
    st = t;
    hold(1, 0, 1, 15);
    hold(0, 0, 1, 12);
    chk("rstmid_count", n5, 1);
    chk("rstmid_latency", last_coin_t, st + 6);

    // Randomized sticky sensor levels, accept toggling, occasional reset
    r5 = 0; r10 = 0; racc = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) r5 = !r5;
      if ($urandom_range(7) == 0) r10 = !r10;
      if ($urandom_range(19) == 0) racc = !racc;
      tick(r5, r10, racc, $urandom_range(149) == 0);
    end
    hold(0, 0, 1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
